// File: rtl/rs_multi_cdb.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// wakes operands from CDB_N broadcast channels, issues oldest-ready via valid/ready.
module rs_multi_cdb #(
    parameter int DEPTH  = 16,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int CDB_N  = 2,
    parameter int OP_W   = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic [ROB_W-1:0]          rob_head,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [ROB_W-1:0]          disp_rob_pos,
    input  logic [OP_W-1:0]           disp_op,
    input  logic                      disp_rs1_rdy,
    input  logic [DATA_W-1:0]         disp_rs1_val,
    input  logic [ROB_W-1:0]          disp_rs1_tag,
    input  logic                      disp_rs2_rdy,
    input  logic [DATA_W-1:0]         disp_rs2_val,
    input  logic [ROB_W-1:0]          disp_rs2_tag,
    input  logic [DATA_W-1:0]         disp_imm,
    input  logic [DATA_W-1:0]         disp_pc,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]    cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]   cdb_val,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [ROB_W-1:0]          iss_rob_pos,
    output logic [OP_W-1:0]           iss_op,
    output logic [DATA_W-1:0]         iss_val1,
    output logic [DATA_W-1:0]         iss_val2,
    output logic [DATA_W-1:0]         iss_imm,
    output logic [DATA_W-1:0]         iss_pc,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic              busy   [DEPTH];
    logic [ROB_W-1:0]  e_rob  [DEPTH];
    logic [OP_W-1:0]   e_op   [DEPTH];
    logic              e_rdy1 [DEPTH];
    logic [DATA_W-1:0] e_val1 [DEPTH];
    logic [ROB_W-1:0]  e_tag1 [DEPTH];
    logic              e_rdy2 [DEPTH];
    logic [DATA_W-1:0] e_val2 [DEPTH];
    logic [ROB_W-1:0]  e_tag2 [DEPTH];
    logic [DATA_W-1:0] e_imm  [DEPTH];
    logic [DATA_W-1:0] e_pc   [DEPTH];

    // Result is {hit, value}; scanning downward lets the lowest channel win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_W-1:0]        tag,
        input logic [CDB_N-1:0]        vld,
        input logic [CDB_N*ROB_W-1:0]  tags,
        input logic [CDB_N*DATA_W-1:0] vals
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (vld[c] && tags[c*ROB_W +: ROB_W] == tag) r = {1'b1, vals[c*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    logic [DATA_W:0] wake1 [DEPTH];
    logic [DATA_W:0] wake2 [DEPTH];
    logic [DATA_W:0] byp1, byp2;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = cdb_lookup(e_tag1[i], cdb_valid, cdb_tag, cdb_val);
            wake2[i] = cdb_lookup(e_tag2[i], cdb_valid, cdb_tag, cdb_val);
        end
        byp1 = cdb_lookup(disp_rs1_tag, cdb_valid, cdb_tag, cdb_val);
        byp2 = cdb_lookup(disp_rs2_tag, cdb_valid, cdb_tag, cdb_val);
    end

    logic [IDX_W-1:0] free_idx, sel_idx;
    logic [ROB_W-1:0] sel_age;
    logic             sel_found;

    always_comb begin : pick
        logic [ROB_W-1:0] age;
        age       = '0;
        free_idx  = '0;
        sel_idx   = '0;
        sel_age   = '0;
        sel_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
        // Age is distance from the ROB head, so wrap-around ordering stays correct.
        for (int i = 0; i < DEPTH; i++) begin
            age = e_rob[i] - rob_head;
            if (busy[i] && e_rdy1[i] && e_rdy2[i] && (!sel_found || age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age;
            end
        end
    end

    logic disp_acc, issue_load;
    assign disp_ready = (occupancy != OCC_W'(DEPTH));
    assign disp_acc   = disp_valid && disp_ready;
    assign issue_load = sel_found && (!iss_valid || iss_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) busy[i] <= 1'b0;
            iss_valid   <= 1'b0;
            occupancy   <= '0;
            iss_rob_pos <= '0;
            iss_op      <= '0;
            iss_val1    <= '0;
            iss_val2    <= '0;
            iss_imm     <= '0;
            iss_pc      <= '0;
        end else if (rdy) begin
            if (rollback) begin
                for (int i = 0; i < DEPTH; i++) busy[i] <= 1'b0;
                iss_valid <= 1'b0;
                occupancy <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i] && !e_rdy1[i] && wake1[i][DATA_W]) begin
                        e_rdy1[i] <= 1'b1;
                        e_val1[i] <= wake1[i][DATA_W-1:0];
                    end
                    if (busy[i] && !e_rdy2[i] && wake2[i][DATA_W]) begin
                        e_rdy2[i] <= 1'b1;
                        e_val2[i] <= wake2[i][DATA_W-1:0];
                    end
                end
                if (issue_load) begin
                    busy[sel_idx] <= 1'b0;
                    iss_valid     <= 1'b1;
                    iss_rob_pos   <= e_rob[sel_idx];
                    iss_op        <= e_op[sel_idx];
                    iss_val1      <= e_val1[sel_idx];
                    iss_val2      <= e_val2[sel_idx];
                    iss_imm       <= e_imm[sel_idx];
                    iss_pc        <= e_pc[sel_idx];
                end else if (iss_ready) begin
                    iss_valid <= 1'b0;
                end
                if (disp_acc) begin
                    busy[free_idx]   <= 1'b1;
                    e_rob[free_idx]  <= disp_rob_pos;
                    e_op[free_idx]   <= disp_op;
                    e_rdy1[free_idx] <= disp_rs1_rdy | byp1[DATA_W];
                    e_val1[free_idx] <= disp_rs1_rdy ? disp_rs1_val : byp1[DATA_W-1:0];
                    e_tag1[free_idx] <= disp_rs1_tag;
                    e_rdy2[free_idx] <= disp_rs2_rdy | byp2[DATA_W];
                    e_val2[free_idx] <= disp_rs2_rdy ? disp_rs2_val : byp2[DATA_W-1:0];
                    e_tag2[free_idx] <= disp_rs2_tag;
                    e_imm[free_idx]  <= disp_imm;
                    e_pc[free_idx]   <= disp_pc;
                end
                occupancy <= occupancy + OCC_W'(disp_acc) - OCC_W'(issue_load);
            end
        end
    end
endmodule
